alu_share_arbiter: RTL

//  Shares one combinational 32-bit ALU between two requesters (port 0: main issue, port 1: auxiliary unit).

---
 rtl/alu_share_arbiter_if.sv | 44 ++++
 rtl/alu_share_arbiter.sv | 111 +++++++++++
 2 files changed

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between the two ALU requesters and the shared-ALU arbiter.
// The arbiter uses the slave view and each requester drives through the master view.
interface alu_share_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4
);
    logic              req0_valid;
    logic              req0_ready;
    logic [OP_W-1:0]   req0_op;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;
    logic              req1_valid;
    logic              req1_ready;
    logic [OP_W-1:0]   req1_op;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;
    logic              rsp0_valid;
    logic              rsp0_ready;
    logic              rsp1_valid;
    logic              rsp1_ready;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_cout;
    logic              rsp_of;
    logic              rsp_z;
    logic              rsp_err;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  rsp0_ready, rsp1_ready,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid,
        output rsp_result, rsp_cout, rsp_of, rsp_z, rsp_err
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output rsp0_ready, rsp1_ready,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid,
        input  rsp_result, rsp_cout, rsp_of, rsp_z, rsp_err
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational ALU between two requesters; one operation in
// flight at a time, with operands registered in front of the ALU and results behind it.
module alu_share_arbiter #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    alu_share_arbiter_if.slave bus,
    output logic [OP_W-1:0]   o_alu_op,
    output logic [DATA_W-1:0] o_alu_in1,
    output logic [DATA_W-1:0] o_alu_in2,
    input  logic [DATA_W-1:0] i_alu_result,
    input  logic              i_alu_cout,
    input  logic              i_alu_of
);
    localparam logic [OP_W-1:0] LAST_LEGAL_OP = OP_W'(9);

    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_t;

    state_t            r_state;
    logic              r_last_grant;
    logic              r_grant;
    logic [OP_W-1:0]   r_op;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_result;
    logic              r_cout;
    logic              r_of;
    logic              r_z;
    logic              r_err;
    logic              r_rsp0_valid;
    logic              r_rsp1_valid;

    logic w_idle;
    logic w_grant0;
    logic w_grant1;
    logic w_illegal;
    logic w_rsp_done;

    // r_last_grant=1 means port 1 was served last, so port 0 wins the next tie.
    assign w_idle     = i_rst_n && (r_state == ST_IDLE);
    assign w_grant0   = w_idle && bus.req0_valid && (!bus.req1_valid || r_last_grant);
    assign w_grant1   = w_idle && bus.req1_valid && (!bus.req0_valid || !r_last_grant);
    assign w_illegal  = (r_op > LAST_LEGAL_OP);
    assign w_rsp_done = (r_rsp0_valid && bus.rsp0_ready) || (r_rsp1_valid && bus.rsp1_ready);

    assign bus.req0_ready = w_grant0;
    assign bus.req1_ready = w_grant1;
    assign bus.rsp0_valid = r_rsp0_valid;
    assign bus.rsp1_valid = r_rsp1_valid;
    assign bus.rsp_result = r_result;
    assign bus.rsp_cout   = r_cout;
    assign bus.rsp_of     = r_of;
    assign bus.rsp_z      = r_z;
    assign bus.rsp_err    = r_err;

    assign o_alu_op  = r_op;
    assign o_alu_in1 = r_a;
    assign o_alu_in2 = r_b;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_grant      <= 1'b0;
            r_op         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_result     <= '0;
            r_cout       <= 1'b0;
            r_of         <= 1'b0;
            r_z          <= 1'b0;
            r_err        <= 1'b0;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant0 || w_grant1) begin
                        r_grant <= w_grant1;
                        r_op    <= w_grant1 ? bus.req1_op : bus.req0_op;
                        r_a     <= w_grant1 ? bus.req1_a  : bus.req0_a;
                        r_b     <= w_grant1 ? bus.req1_b  : bus.req0_b;
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // Illegal opcodes ignore whatever the ALU produced.
                    r_result     <= w_illegal ? '0 : i_alu_result;
                    r_cout       <= !w_illegal && i_alu_cout;
                    r_of         <= !w_illegal && i_alu_of;
                    r_z          <= w_illegal || (i_alu_result == '0);
                    r_err        <= w_illegal;
                    r_rsp0_valid <= !r_grant;
                    r_rsp1_valid <= r_grant;
                    r_state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (w_rsp_done) begin
                        r_rsp0_valid <= 1'b0;
                        r_rsp1_valid <= 1'b0;
                        r_last_grant <= r_grant;
                        r_state      <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule
